// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control sequencer.
//  mode_t     : encoding of the Mode output (RUN=0, PAUSE=1, ADJ=2); the display mux
//               and time counter decode the same values.
//  next_mode  : mode selection from the debounced Adjust level and the Paused flag.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_PAUSE = 2'd1,
        MODE_ADJ   = 2'd2
    } mode_t;

    // Index of each raw switch inside the debounced bus.
    localparam int SW_PAUSE  = 0;
    localparam int SW_ADJUST = 1;
    localparam int SW_SELECT = 2;
    localparam int SW_COUNT  = 3;

    // Adjust wins over pause; leaving adjust falls back on whatever Paused is.
    function automatic mode_t next_mode(input logic adjust, input logic paused);
        if (adjust) begin
            return MODE_ADJ;
        end else if (paused) begin
            return MODE_PAUSE;
        end
        return MODE_RUN;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce_cell.sv
// debounce_cell: two-flop synchroniser followed by a persistence counter.
//  FasterClock : clock
//  Reset       : asynchronous active-high reset, clears all state
//  din         : raw asynchronous switch level
//  dout        : debounced level; follows a clean change of din at edge 2+STABLE_CYCLES
module debounce_cell #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 5
) (
    input  logic FasterClock,
    input  logic Reset,
    input  logic din,
    output logic dout
);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge FasterClock or posedge Reset) begin
        if (Reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            // The counter measures how long the synchronised level has
            // disagreed with dout; any agreement restarts the count, so a
            // short glitch never reaches the flip threshold.
            if (sync == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                dout <= sync;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounces the Pause/Adjust/Select switches and runs the
// RUN/PAUSE/ADJ mode machine that drives the time counter and display.
//  FasterClock : sole clock
//  Reset       : asynchronous active-high reset
//  PauseIn     : raw pause button, 1 = pressed
//  AdjustIn    : raw adjust switch, 1 = adjust mode
//  SelectIn    : raw select switch, 0 = seconds, 1 = minutes
//  TickNormal  : 1 Hz one-cycle enable
//  TickAdjust  : 2 Hz one-cycle enable
//  Mode        : 0 RUN, 1 PAUSE, 2 ADJ
//  Paused      : pause flag, toggled by each press
//  IncSec      : one-cycle "add one second" pulse
//  IncMin      : one-cycle "add one minute" pulse
//  AdjSel      : debounced Select level
//  BlinkPhase  : 1 = blank the field being adjusted
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 5
) (
    input  logic       FasterClock,
    input  logic       Reset,
    input  logic       PauseIn,
    input  logic       AdjustIn,
    input  logic       SelectIn,
    input  logic       TickNormal,
    input  logic       TickAdjust,
    output logic [1:0] Mode,
    output logic       Paused,
    output logic       IncSec,
    output logic       IncMin,
    output logic       AdjSel,
    output logic       BlinkPhase
);

    logic [SW_COUNT-1:0] raw;
    logic [SW_COUNT-1:0] db;

    assign raw[SW_PAUSE]  = PauseIn;
    assign raw[SW_ADJUST] = AdjustIn;
    assign raw[SW_SELECT] = SelectIn;

    generate
        for (genvar gi = 0; gi < SW_COUNT; gi++) begin : g_debounce
            debounce_cell #(
                .STABLE_CYCLES (STABLE_CYCLES),
                .CNT_W         (CNT_W)
            ) u_debounce (
                .FasterClock (FasterClock),
                .Reset       (Reset),
                .din         (raw[gi]),
                .dout        (db[gi])
            );
        end
    endgenerate

    logic  db_pause_q;
    logic  press;
    mode_t mode_reg;
    logic  paused_reg;
    logic  inc_sec_reg;
    logic  inc_min_reg;
    logic  adj_sel_reg;
    logic  blink_reg;

    // Rising edge of the debounced pause level; release is ignored.
    assign press = db[SW_PAUSE] & ~db_pause_q;

    // Mode and pulses are both computed from the pre-edge state, so a tick
    // landing on a mode-change edge is handled under the old mode.
    always_ff @(posedge FasterClock or posedge Reset) begin
        if (Reset) begin
            db_pause_q  <= 1'b0;
            mode_reg    <= MODE_RUN;
            paused_reg  <= 1'b0;
            inc_sec_reg <= 1'b0;
            inc_min_reg <= 1'b0;
            adj_sel_reg <= 1'b0;
            blink_reg   <= 1'b0;
        end else begin
            db_pause_q  <= db[SW_PAUSE];
            mode_reg    <= next_mode(db[SW_ADJUST], paused_reg);
            adj_sel_reg <= db[SW_SELECT];
            if (press) begin
                paused_reg <= ~paused_reg;
            end

            inc_sec_reg <= 1'b0;
            inc_min_reg <= 1'b0;
            blink_reg   <= 1'b0;
            case (mode_reg)
                MODE_RUN: begin
                    inc_sec_reg <= TickNormal;
                end
                MODE_ADJ: begin
                    if (TickAdjust) begin
                        inc_min_reg <= db[SW_SELECT];
                        inc_sec_reg <= ~db[SW_SELECT];
                    end
                    // Blink only survives while adjust stays asserted; the
                    // edge that leaves ADJ clears it.
                    if (db[SW_ADJUST]) begin
                        blink_reg <= blink_reg ^ TickAdjust;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Mode       = mode_reg;
    assign Paused     = paused_reg;
    assign IncSec     = inc_sec_reg;
    assign IncMin     = inc_min_reg;
    assign AdjSel     = adj_sel_reg;
    assign BlinkPhase = blink_reg;

endmodule
